// File: rtl/tdm_arb_pkg.sv
// Shared types and constants for the 4-source TDM link arbiter.
package tdm_arb_pkg;
  localparam int NCH  = 4;
  localparam int IDXW = 2;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational 4-way round-robin picker: first requester after ptr wins.
module rr_arbiter
  import tdm_arb_pkg::*;
(
  input  logic [NCH-1:0]  req,
  input  logic [IDXW-1:0] ptr,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_any
);

  logic [IDXW-1:0] idx;

  // Scan from lowest priority (ptr itself) to highest (ptr+1) so the last hit wins.
  always_comb begin
    gnt_any = |req;
    gnt_idx = ptr;
    idx     = ptr;
    for (int i = NCH; i >= 1; i--) begin
      idx = ptr + IDXW'(i);
      if (req[idx]) gnt_idx = idx;
    end
  end

endmodule

// File: rtl/tdm_link_arbiter.sv
// Burst-granular round-robin arbiter from 4 sources onto a shared 4-destination link.
module tdm_link_arbiter
  import tdm_arb_pkg::*;
#(
  parameter int DW        = 4,
  parameter int BURST_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NCH-1:0]      src_valid,
  input  logic [NCH-1:0]      src_last,
  input  logic [NCH*DW-1:0]   src_data,
  input  logic [NCH*IDXW-1:0] src_dest,
  output logic [NCH-1:0]      src_ready,
  output logic [NCH-1:0]      dst_valid,
  output logic [DW-1:0]       dst_data,
  output logic                dst_last,
  input  logic [NCH-1:0]      dst_ready,
  output logic [IDXW-1:0]     sel,
  output logic                busy
);

  localparam logic [4:0] LAST_CNT = 5'(BURST_MAX - 1);

  state_t          state;
  logic [IDXW-1:0] ptr;
  logic [IDXW-1:0] dest_lat;
  logic [IDXW-1:0] out_dest;
  logic [4:0]      beat_cnt;
  logic            out_valid;
  logic [DW-1:0]   data_q;
  logic            last_q;

  logic [IDXW-1:0] gnt_idx;
  logic            gnt_any;
  logic            fire;
  logic            drain;
  logic            end_beat;

  rr_arbiter u_rr (
    .req     (src_valid),
    .ptr     (ptr),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // The granted source may push whenever the single output slot is empty or emptying.
  always_comb begin
    src_ready = '0;
    if (state == XFER) src_ready[sel] = !out_valid || dst_ready[out_dest];
  end

  assign fire     = (state == XFER) && src_valid[sel] && src_ready[sel];
  assign drain    = out_valid && dst_ready[out_dest];
  assign end_beat = src_last[sel] || (beat_cnt == LAST_CNT);

  assign dst_valid = out_valid ? (NCH'(1) << out_dest) : '0;
  assign dst_data  = data_q;
  assign dst_last  = last_q;
  assign busy      = (state == XFER);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= IDXW'(NCH - 1);
      sel       <= '0;
      dest_lat  <= '0;
      beat_cnt  <= '0;
      out_valid <= 1'b0;
      out_dest  <= '0;
      data_q    <= '0;
      last_q    <= 1'b0;
    end else begin
      // Output register: load on handshake, otherwise empty once drained.
      if (fire) begin
        out_valid <= 1'b1;
        out_dest  <= dest_lat;
        data_q    <= src_data[sel*DW +: DW];
        last_q    <= end_beat;
      end else if (drain) begin
        out_valid <= 1'b0;
        last_q    <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (gnt_any) begin
            sel      <= gnt_idx;
            dest_lat <= src_dest[gnt_idx*IDXW +: IDXW];
            beat_cnt <= '0;
            state    <= XFER;
          end
        end
        XFER: begin
          if (fire) begin
            if (end_beat) begin
              beat_cnt <= '0;
              ptr      <= sel;
              state    <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + 5'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tdm_link_arbiter.sv
// Directed bench for tdm_link_arbiter: cycle tables plus multi-cycle corner sequences.
module tb_tdm_link_arbiter;
  localparam int DW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  src_valid, src_last, src_ready, dst_valid, dst_ready;
  logic [15:0] src_data;
  logic [7:0]  src_dest;
  logic [3:0]  dst_data;
  logic        dst_last, busy;
  logic [1:0]  sel;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int         hs_sel[$];
  int         hs_cyc[$];
  logic [3:0] out_data[$];
  logic       out_last[$];
  logic [3:0] out_dv[$];

  tdm_link_arbiter #(.DW(DW), .BURST_MAX(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .src_valid (src_valid),
    .src_last  (src_last),
    .src_data  (src_data),
    .src_dest  (src_dest),
    .src_ready (src_ready),
    .dst_valid (dst_valid),
    .dst_data  (dst_data),
    .dst_last  (dst_last),
    .dst_ready (dst_ready),
    .sel       (sel),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record source handshakes and delivered output beats.
  always @(negedge clk) begin
    if (!rst) begin
      if (|(src_valid & src_ready)) begin
        hs_sel.push_back(int'(sel));
        hs_cyc.push_back(cyc);
      end
      if (|(dst_valid & dst_ready)) begin
        out_data.push_back(dst_data);
        out_last.push_back(dst_last);
        out_dv.push_back(dst_valid);
      end
    end
  end

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [15:0] data;
    logic [7:0]  dest;
    logic [3:0]  dready;
    logic [3:0]  e_srdy;
    logic [3:0]  e_dv;
    logic [3:0]  e_data;
    logic        e_last;
    logic [1:0]  e_sel;
    logic        e_busy;
    logic        chk_data;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l, input logic [15:0] d,
                              input logic [7:0] de, input logic [3:0] dr, input logic [3:0] es,
                              input logic [3:0] edv, input logic [3:0] ed, input logic el,
                              input logic [1:0] esel, input logic eb, input logic cd);
    vec_t t;
    t.valid = v; t.last = l; t.data = d; t.dest = de; t.dready = dr;
    t.e_srdy = es; t.e_dv = edv; t.e_data = ed; t.e_last = el;
    t.e_sel = esel; t.e_busy = eb; t.chk_data = cd;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    src_valid = '0;
    src_last  = '0;
    src_data  = '0;
    src_dest  = '0;
    dst_ready = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    hs_sel.delete(); hs_cyc.delete();
    out_data.delete(); out_last.delete(); out_dv.delete();
  endtask

  task automatic run_table(input string tag);
    for (int r = 0; r < tbl.size(); r++) begin
      src_valid = tbl[r].valid;
      src_last  = tbl[r].last;
      src_data  = tbl[r].data;
      src_dest  = tbl[r].dest;
      dst_ready = tbl[r].dready;
      @(negedge clk);
      chk($sformatf("%s_r%0d_src_ready", tag, r), 32'(src_ready), 32'(tbl[r].e_srdy));
      chk($sformatf("%s_r%0d_dst_valid", tag, r), 32'(dst_valid), 32'(tbl[r].e_dv));
      chk($sformatf("%s_r%0d_dst_last", tag, r), 32'(dst_last), 32'(tbl[r].e_last));
      chk($sformatf("%s_r%0d_sel", tag, r), 32'(sel), 32'(tbl[r].e_sel));
      chk($sformatf("%s_r%0d_busy", tag, r), 32'(busy), 32'(tbl[r].e_busy));
      if (tbl[r].chk_data)
        chk($sformatf("%s_r%0d_dst_data", tag, r), 32'(dst_data), 32'(tbl[r].e_data));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_burst(input int s, input int n, input logic [1:0] d,
                             input logic use_last, input logic [DW-1:0] base);
    int   k = 0;
    int   guard = 0;
    logic hs;
    src_dest[2*s +: 2] = d;
    while (k < n && guard < 200) begin
      src_valid[s]           = 1'b1;
      src_data[s*DW +: DW]   = DW'(k + int'(base));
      src_last[s]            = use_last && (k == n - 1);
      @(negedge clk);
      hs = src_valid[s] && src_ready[s];
      @(posedge clk);
      #1;
      if (hs) k++;
      guard++;
    end
    src_valid[s] = 1'b0;
    src_last[s]  = 1'b0;
    chk($sformatf("burst_src%0d_beats_sent", s), 32'(k), 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         g;
    logic [3:0] exp_last6 [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [3:0] exp_d4    [4] = '{4'h7, 4'h8, 4'h9, 4'hA};
    logic       exp_l4    [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int         exp_rr    [5] = '{0, 1, 2, 3, 0};

    // Source 2 -> dest 3, beats A,B,C with last on C.
    do_reset();
    tbl.delete();
    tbl.push_back(mk(4'b0100, 4'b0000, 16'h0000, 8'h30, 4'hF, 4'b0000, 4'b0000, 4'h0, 1'b0, 2'd0, 1'b0, 1'b1));
    tbl.push_back(mk(4'b0100, 4'b0000, 16'h0A00, 8'h30, 4'hF, 4'b0100, 4'b0000, 4'h0, 1'b0, 2'd2, 1'b1, 1'b0));
    tbl.push_back(mk(4'b0100, 4'b0000, 16'h0B00, 8'h30, 4'hF, 4'b0100, 4'b1000, 4'hA, 1'b0, 2'd2, 1'b1, 1'b1));
    tbl.push_back(mk(4'b0100, 4'b0100, 16'h0C00, 8'h30, 4'hF, 4'b0100, 4'b1000, 4'hB, 1'b0, 2'd2, 1'b1, 1'b1));
    tbl.push_back(mk(4'b0000, 4'b0000, 16'h0000, 8'h30, 4'hF, 4'b0000, 4'b1000, 4'hC, 1'b1, 2'd2, 1'b0, 1'b1));
    tbl.push_back(mk(4'b0000, 4'b0000, 16'h0000, 8'h30, 4'hF, 4'b0000, 4'b0000, 4'h0, 1'b0, 2'd2, 1'b0, 1'b0));
    run_table("abc");

    // Sources 1 and 3 request together: 1 wins and completes, then 3.
    do_reset();
    tbl.delete();
    tbl.push_back(mk(4'b1010, 4'b1010, 16'h3010, 8'h40, 4'hF, 4'b0000, 4'b0000, 4'h0, 1'b0, 2'd0, 1'b0, 1'b1));
    tbl.push_back(mk(4'b1010, 4'b1010, 16'h3010, 8'h40, 4'hF, 4'b0010, 4'b0000, 4'h0, 1'b0, 2'd1, 1'b1, 1'b0));
    tbl.push_back(mk(4'b1000, 4'b1000, 16'h3010, 8'h40, 4'hF, 4'b0000, 4'b0001, 4'h1, 1'b1, 2'd1, 1'b0, 1'b1));
    tbl.push_back(mk(4'b1000, 4'b1000, 16'h3010, 8'h40, 4'hF, 4'b1000, 4'b0000, 4'h0, 1'b0, 2'd3, 1'b1, 1'b0));
    tbl.push_back(mk(4'b0000, 4'b0000, 16'h3010, 8'h40, 4'hF, 4'b0000, 4'b0010, 4'h3, 1'b1, 2'd3, 1'b0, 1'b1));
    run_table("rr13");

    // Six beats without last: cut at beat 4, beats 5-6 under a fresh grant.
    do_reset();
    drive_burst(0, 6, 2'd2, 1'b0, 4'h1);
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("bmax_hs_count", 32'(hs_sel.size()), 32'd6);
    chk("bmax_out_count", 32'(out_data.size()), 32'd6);
    if (hs_cyc.size() >= 5)
      chk("bmax_regrant_gap", 32'(hs_cyc[4] - hs_cyc[3]), 32'd2);
    for (int i = 0; i < 6 && i < out_data.size(); i++) begin
      chk($sformatf("bmax_data%0d", i), 32'(out_data[i]), 32'(i + 1));
      chk($sformatf("bmax_last%0d", i), 32'(out_last[i]), 32'(exp_last6[i]));
      chk($sformatf("bmax_dv%0d", i), 32'(out_dv[i]), 32'h4);
    end

    // Destination 1 stalls for 5 cycles mid-burst.
    do_reset();
    fork
      drive_burst(1, 4, 2'd1, 1'b1, 4'h7);
      begin
        g = 0;
        @(negedge clk);
        while (dst_valid[1] == 1'b0 && g < 100) begin
          @(negedge clk);
          g++;
        end
        chk("stall_first_beat_seen", 32'(dst_valid[1]), 32'd1);
        @(posedge clk);
        #1;
        dst_ready = 4'b1101;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk($sformatf("stall%0d_data", i), 32'(dst_data), 32'h8);
          chk($sformatf("stall%0d_dv", i), 32'(dst_valid), 32'b0010);
          chk($sformatf("stall%0d_src_ready", i), 32'(src_ready[1]), 32'd0);
        end
        @(posedge clk);
        #1;
        dst_ready = 4'hF;
      end
    join
    repeat (2) @(posedge clk);
    #1;
    chk("stall_out_count", 32'(out_data.size()), 32'd4);
    for (int i = 0; i < 4 && i < out_data.size(); i++) begin
      chk($sformatf("stall_out_data%0d", i), 32'(out_data[i]), 32'(exp_d4[i]));
      chk($sformatf("stall_out_last%0d", i), 32'(out_last[i]), 32'(exp_l4[i]));
    end

    // All sources always valid with 1-beat bursts.
    do_reset();
    src_dest  = 8'hE4;
    src_data  = 16'h3210;
    src_last  = 4'hF;
    src_valid = 4'hF;
    g = 0;
    while (hs_sel.size() < 5 && g < 100) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    #1;
    src_valid = 4'h0;
    chk("rr4_enough_grants", 32'(hs_sel.size() >= 5), 32'd1);
    for (int i = 0; i < 5 && i < hs_sel.size(); i++)
      chk($sformatf("rr4_grant%0d", i), 32'(hs_sel[i]), 32'(exp_rr[i]));

    // Reset during beat 2 of a 4-beat burst from source 2.
    do_reset();
    src_dest  = 8'h00;
    src_data  = 16'h0500;
    src_valid = 4'b0100;
    g = 0;
    @(negedge clk);
    while (src_ready[2] == 1'b0 && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("rstmid_beat1_ready", 32'(src_ready[2]), 32'd1);
    @(posedge clk);
    #1;
    src_data = 16'h0600;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    chk("rstmid_src_ready", 32'(src_ready), 32'd0);
    chk("rstmid_dst_valid", 32'(dst_valid), 32'd0);
    chk("rstmid_dst_data", 32'(dst_data), 32'd0);
    chk("rstmid_dst_last", 32'(dst_last), 32'd0);
    chk("rstmid_sel", 32'(sel), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    rst       = 1'b0;
    src_valid = 4'b0101;
    src_data  = 16'h0601;
    @(posedge clk);
    #1;
    chk("rstmid_regrant_sel", 32'(sel), 32'd0);
    chk("rstmid_regrant_busy", 32'(busy), 32'd1);
    chk("rstmid_no_stale_out", 32'(dst_valid), 32'd0);
    src_valid = 4'b0000;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tdm_link_arbiter.md
TDM_LINK_ARBITER -- requirements
Module: tdm_link_arbiter

Interface
REQ-001 The block SHALL have parameter DW, default 4, meaning per-beat data width.
REQ-002 The block SHALL have parameter BURST_MAX, default 4, meaning the maximum beats per grant (legal range 1..16).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all logic rising-edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port src_valid, input, 4 bits: per-source beat valid.
REQ-006 The block SHALL have port src_last, input, 4 bits: per-source end-of-burst marker.
REQ-007 The block SHALL have port src_data, input, 4*DW bits: source i data at [i*DW +: DW].
REQ-008 The block SHALL have port src_dest, input, 8 bits: source i destination index at [2i+1:2i].
REQ-009 The block SHALL have port src_ready, output, 4 bits: per-source beat accept.
REQ-010 The block SHALL have port dst_valid, output, 4 bits: one-hot destination valid.
REQ-011 The block SHALL have port dst_data, output, DW bits: data shared by all destinations.
REQ-012 The block SHALL have port dst_last, output, 1 bit: final beat of a burst.
REQ-013 The block SHALL have port dst_ready, input, 4 bits: per-destination accept.
REQ-014 The block SHALL have port sel, output, 2 bits: currently granted source index.
REQ-015 The block SHALL have port busy, output, 1 bit: high while in XFER.

Function
REQ-016 The FSM SHALL have exactly two states, IDLE and XFER.
REQ-017 In IDLE with any src_valid high, the block SHALL grant the first requesting source after ptr in round-robin order (ptr+1, ptr+2, ... mod 4), and SHALL latch that source's grant index and src_dest; XFER, sel and busy SHALL take effect the next cycle.
REQ-018 In IDLE, src_ready SHALL be 4'b0000.
REQ-019 In XFER, only src_ready[sel] SHALL be able to assert, with src_ready[sel] = !out_valid || dst_ready[out_dest], where out_valid and out_dest describe the single-entry output register.
REQ-020 A beat SHALL transfer when src_valid[sel] && src_ready[sel]; dst_data, dst_last and dst_valid[latched dest] SHALL be registered and SHALL appear the cycle after the handshake (latency 1).
REQ-021 A burst SHALL end on the beat carrying src_last[sel], or on beat BURST_MAX when src_last is absent; on the ending beat, dst_last SHALL be 1, ptr SHALL become sel, and the FSM SHALL return to IDLE.
REQ-022 Destination SHALL be fixed per burst; src_dest changes during XFER SHALL be ignored.
REQ-023 While dst_valid is high and dst_ready[out_dest] is low, dst_data, dst_valid and dst_last SHALL hold stable.
REQ-024 When the output register drains with no new beat, dst_valid SHALL return to 0.
REQ-025 A gap in src_valid[sel] during XFER SHALL keep the grant; no timeout SHALL apply.
REQ-026 Arbitration in IDLE SHALL be allowed while the output register still holds the prior burst's last beat; the first beat of the new burst SHALL wait per REQ-019.
REQ-027 BURST_MAX=1 SHALL force dst_last=1 on every beat.

Reset
REQ-028 On rst, the block SHALL enter IDLE with ptr=3 (source 0 has first priority) and beat counter=0.
REQ-029 On rst, src_ready, dst_valid, dst_last, sel and busy SHALL be 0, and dst_data SHALL be 0.
REQ-030 rst mid-burst SHALL discard the in-flight beat and output register contents; no partial burst SHALL resume.

Structure
REQ-031 Package tdm_arb_pkg SHALL hold the state enum (IDLE, XFER), constant NCH=4 and constant IDXW=2.
REQ-032 Sub-module rr_arbiter SHALL be a combinational 4-way round-robin picker: inputs req[3:0] and ptr[1:0]; outputs gnt_idx[1:0] and gnt_any.

Verification
REQ-033 The bench SHALL cover: after reset, src_valid=4'b1010 -> sel=1 and its burst completes first, then sel=3.
REQ-034 The bench SHALL cover: source 2, dest 3, 3 beats A,B,C with src_last on C, dst_ready=4'hF -> dst_valid=4'b1000 for 3 consecutive cycles, each beat 1 cycle after its handshake, dst_last only with C.
REQ-035 The bench SHALL cover: BURST_MAX=4, source 0 sends 6 beats with no src_last -> dst_last on beat 4, FSM returns to IDLE, and beats 5-6 arrive in a new grant.
REQ-036 The bench SHALL cover: dst_ready[1]=0 for 5 cycles mid-burst -> dst_data held constant, src_ready[sel]=0, no beat lost or duplicated.
REQ-037 The bench SHALL cover: all 4 sources continuously valid with 1-beat bursts -> grant order 0,1,2,3,0.
REQ-038 The bench SHALL cover: rst asserted on beat 2 of 4 -> the next cycle shows all outputs 0 and IDLE, and the next grant goes to source 0.
